saturn_fetch_queue: RTL and testbench

//  Nibble prefetch queue sitting directly upstream of saturn_alu's instruction/operand path.

---
 rtl/saturn_fetch_queue.sv | 144 ++++++++++++++
 tb/tb_saturn_fetch_queue.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/saturn_fetch_queue.sv
// Nibble prefetch queue feeding the decode/ALU stage: issues sequential single-nibble bus
// reads from a 20-bit fetch PC and delivers address-tagged nibbles over valid/ready.
module saturn_fetch_queue #(
    parameter int unsigned DEPTH    = 8,
    parameter logic [19:0] RESET_PC = 20'h00000
) (
    input  logic        strobe,
    input  logic        reset,
    input  logic        redirect_en,
    input  logic [19:0] redirect_pc,
    output logic        bus_read,
    output logic [19:0] bus_addr,
    input  logic        bus_ack,
    input  logic [3:0]  bus_nibble,
    input  logic        bus_error,
    output logic        nib_valid,
    output logic [3:0]  nib_data,
    output logic [19:0] nib_addr,
    input  logic        nib_ready,
    output logic        fault,
    output logic [19:0] fault_addr
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DRAIN, ST_FAULT} state_t;

    state_t        r_state, w_state_next;
    logic [19:0]   r_fetch_pc, w_fetch_pc_next;
    logic [19:0]   r_bus_addr;
    logic [CW-1:0] r_count, w_count_after_pop, w_count_next;
    logic [AW-1:0] r_rd_ptr, r_wr_ptr, w_rd_ptr_next;
    logic [3:0]    r_mem_data [DEPTH];
    logic [19:0]   r_mem_addr [DEPTH];
    logic          r_fault;
    logic [19:0]   r_fault_addr;
    logic [3:0]    r_nib_data, w_nib_data_next;
    logic [19:0]   r_nib_addr, w_nib_addr_next;
    logic          w_busy, w_push, w_pop, w_fault_set;

    always_comb begin
        w_busy            = (r_state == ST_REQ) || (r_state == ST_DRAIN);
        w_push            = (r_state == ST_REQ) && bus_ack && !bus_error && !redirect_en;
        w_fault_set       = (r_state == ST_REQ) && bus_ack && bus_error && !redirect_en;
        w_pop             = (r_count != '0) && nib_ready && !redirect_en;
        w_count_after_pop = r_count - CW'(w_pop);
        w_count_next      = redirect_en ? '0 : w_count_after_pop + CW'(w_push);
        w_rd_ptr_next     = r_rd_ptr + AW'(w_pop);

        if (redirect_en)
            w_fetch_pc_next = redirect_pc;
        else if (w_push)
            w_fetch_pc_next = r_fetch_pc + 20'd1;
        else
            w_fetch_pc_next = r_fetch_pc;

        w_state_next = r_state;
        if (redirect_en) begin
            // an in-flight read must still complete on the bus; its ack is thrown away in DRAIN
            w_state_next = (w_busy && !bus_ack) ? ST_DRAIN : ST_REQ;
        end else begin
            case (r_state)
                ST_IDLE:  if (r_count < FULL) w_state_next = ST_REQ;
                ST_REQ: begin
                    if (bus_ack) begin
                        if (bus_error)               w_state_next = ST_FAULT;
                        else if (w_count_next < FULL) w_state_next = ST_REQ;
                        else                          w_state_next = ST_IDLE;
                    end
                end
                ST_DRAIN: if (bus_ack) w_state_next = ST_REQ;
                ST_FAULT: w_state_next = ST_FAULT;
                default:  w_state_next = ST_IDLE;
            endcase
        end

        // head registers track the entry that will sit at the front after this edge
        w_nib_data_next = r_nib_data;
        w_nib_addr_next = r_nib_addr;
        if (!redirect_en && (w_count_next != '0)) begin
            if (w_push && (w_count_after_pop == '0)) begin
                w_nib_data_next = bus_nibble;
                w_nib_addr_next = r_bus_addr;
            end else begin
                w_nib_data_next = r_mem_data[w_rd_ptr_next];
                w_nib_addr_next = r_mem_addr[w_rd_ptr_next];
            end
        end
    end

    always_ff @(posedge strobe) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_fetch_pc   <= RESET_PC;
            r_bus_addr   <= '0;
            r_count      <= '0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_fault      <= 1'b0;
            r_fault_addr <= '0;
            r_nib_data   <= '0;
            r_nib_addr   <= '0;
        end else begin
            r_state    <= w_state_next;
            r_fetch_pc <= w_fetch_pc_next;
            r_count    <= w_count_next;
            r_nib_data <= w_nib_data_next;
            r_nib_addr <= w_nib_addr_next;
            if (w_state_next == ST_REQ)
                r_bus_addr <= w_fetch_pc_next;
            if (redirect_en) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                r_rd_ptr <= w_rd_ptr_next;
                if (w_push)
                    r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (redirect_en) begin
                r_fault <= 1'b0;
            end else if (w_fault_set) begin
                r_fault      <= 1'b1;
                r_fault_addr <= r_bus_addr;
            end
        end
    end

    always_ff @(posedge strobe) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= bus_nibble;
            r_mem_addr[r_wr_ptr] <= r_bus_addr;
        end
    end

    assign bus_read   = w_busy;
    assign bus_addr   = r_bus_addr;
    assign nib_valid  = (r_count != '0);
    assign nib_data   = r_nib_data;
    assign nib_addr   = r_nib_addr;
    assign fault      = r_fault;
    assign fault_addr = r_fault_addr;

endmodule

// File: tb/tb_saturn_fetch_queue.sv
// Bench for saturn_fetch_queue: scenario tasks plus randomized traffic against a queue-based
// model of the fetch rules (outstanding read, discard-on-redirect, fault latch, FIFO contents).
module tb_saturn_fetch_queue;
    localparam int unsigned DEPTH = 8;

    logic        strobe = 1'b0;
    logic        reset, redirect_en, bus_ack, bus_error, nib_ready;
    logic [19:0] redirect_pc;
    logic [3:0]  bus_nibble;
    logic        bus_read, nib_valid, fault;
    logic [19:0] bus_addr, nib_addr, fault_addr;
    logic [3:0]  nib_data;

    saturn_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(20'h00000)) dut (
        .strobe(strobe), .reset(reset), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .bus_read(bus_read), .bus_addr(bus_addr), .bus_ack(bus_ack), .bus_nibble(bus_nibble),
        .bus_error(bus_error), .nib_valid(nib_valid), .nib_data(nib_data), .nib_addr(nib_addr),
        .nib_ready(nib_ready), .fault(fault), .fault_addr(fault_addr)
    );

    always #5 strobe = ~strobe;

    typedef struct packed { logic [19:0] a; logic [3:0] d; } ent_t;
    ent_t        mq[$];
    logic [19:0] m_pc, m_oaddr, m_faddr;
    logic        m_out, m_disc, m_fault;
    int          n_cmp = 0;
    int          n_bad = 0;

    // Model: one edge of fetch behaviour, driven by the bench's own input variables
    function automatic void model_step();
        logic was_full;
        if (reset) begin
            mq.delete();
            m_pc = 20'h00000; m_out = 1'b0; m_disc = 1'b0; m_oaddr = '0;
            m_fault = 1'b0; m_faddr = '0;
            return;
        end
        was_full = (mq.size() == DEPTH);
        if (redirect_en) begin
            mq.delete();
            m_pc = redirect_pc;
            m_fault = 1'b0;
            if (m_out && !bus_ack) m_disc = 1'b1;
            else begin m_out = 1'b1; m_disc = 1'b0; m_oaddr = redirect_pc; end
            return;
        end
        if (mq.size() != 0 && nib_ready) void'(mq.pop_front());
        if (m_out) begin
            if (bus_ack) begin
                if (m_disc) begin
                    m_disc = 1'b0; m_oaddr = m_pc;
                end else if (bus_error) begin
                    m_fault = 1'b1; m_faddr = m_oaddr; m_out = 1'b0;
                end else begin
                    mq.push_back('{a: m_oaddr, d: bus_nibble});
                    m_pc = m_pc + 20'd1;
                    m_out = (mq.size() < DEPTH);
                    m_oaddr = m_pc;
                end
            end
        end else if (!m_fault && !was_full) begin
            m_out = 1'b1; m_oaddr = m_pc;
        end
    endfunction

    function automatic logic [66:0] exp_vec();
        logic [3:0]  hd = '0;
        logic [19:0] ha = '0;
        logic        hv = (mq.size() != 0);
        if (hv) begin hd = mq[0].d; ha = mq[0].a; end
        return {m_out, (m_out ? m_oaddr : 20'h0), hv, hd, ha, m_fault, (m_fault ? m_faddr : 20'h0)};
    endfunction

    function automatic logic [66:0] obs_vec();
        return {bus_read, (bus_read ? bus_addr : 20'h0), nib_valid, (nib_valid ? nib_data : 4'h0),
                (nib_valid ? nib_addr : 20'h0), fault, (fault ? fault_addr : 20'h0)};
    endfunction

    task automatic tick();
        @(posedge strobe);
        model_step();
        @(negedge strobe);
    endtask

    task automatic drive_quiet();
        reset = 1'b0; redirect_en = 1'b0; redirect_pc = '0; bus_ack = 1'b0;
        bus_nibble = '0; bus_error = 1'b0; nib_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        drive_quiet();
        bus_ack = 1'b1; nib_ready = 1'b1; reset = 1'b1;
        tick();
        n_cmp++;
        if ({bus_read, bus_addr, nib_valid, nib_data, nib_addr, fault, fault_addr} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got rd=%b ba=%h v=%b d=%h na=%h f=%b fa=%h, want all 0",
                     bus_read, bus_addr, nib_valid, nib_data, nib_addr, fault, fault_addr);
        end
        reset = 1'b0;
        bus_ack = 1'b0;
        tick();
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL reset_release: dut=%h model=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_stream();
        int valid_cnt = 0;
        drive_quiet();
        do_reset();
        nib_ready = 1'b1; bus_ack = 1'b1;
        for (int i = 0; i < 30; i++) begin
            bus_nibble = m_oaddr[3:0];
            tick();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL stream cyc %0d: dut=%h model=%h", i, obs_vec(), exp_vec());
            end
            if (i >= 10 && nib_valid) valid_cnt++;
        end
        n_cmp++;
        if (valid_cnt !== 20) begin
            n_bad++;
            $display("FAIL stream_rate: got %0d valid cycles of 20, want 20", valid_cnt);
        end
    endtask

    task automatic test_full();
        int pushes = 0;
        int reads = 0;
        logic [19:0] read_addr = 20'hFFFFF;
        drive_quiet();
        do_reset();
        bus_ack = 1'b1;
        for (int i = 0; i < 14; i++) begin
            bus_nibble = 4'($urandom);
            if (bus_read && bus_ack) pushes++;
            tick();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL full_fill cyc %0d: dut=%h model=%h", i, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (pushes !== 8 || bus_read !== 1'b0) begin
            n_bad++;
            $display("FAIL full_stop: got pushes=%0d bus_read=%b, want 8 and 0", pushes, bus_read);
        end
        nib_ready = 1'b1;
        tick();
        nib_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (bus_read) begin reads++; read_addr = bus_addr; end
            tick();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL full_refill cyc %0d: dut=%h model=%h", i, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (reads !== 1 || read_addr !== 20'h00008) begin
            n_bad++;
            $display("FAIL full_one_read: got reads=%0d addr=%h, want 1 at 00008", reads, read_addr);
        end
    endtask

    task automatic test_redirect_drain();
        bit seen = 1'b0;
        drive_quiet();
        do_reset();
        bus_ack = 1'b1;
        for (int i = 0; i < 20 && !(m_out && m_oaddr == 20'h00003); i++) begin
            bus_nibble = 4'($urandom);
            tick();
        end
        bus_ack = 1'b0;
        tick();
        redirect_en = 1'b1; redirect_pc = 20'h12345;
        tick();
        redirect_en = 1'b0;
        n_cmp++;
        if (bus_read !== 1'b1 || bus_addr !== 20'h00003 || nib_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL drain_hold: got rd=%b addr=%h v=%b, want 1 00003 0", bus_read, bus_addr, nib_valid);
        end
        tick();
        bus_ack = 1'b1; bus_nibble = 4'hA;
        tick();
        n_cmp++;
        if (bus_read !== 1'b1 || bus_addr !== 20'h12345 || nib_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL drain_next: got rd=%b addr=%h v=%b, want 1 12345 0", bus_read, bus_addr, nib_valid);
        end
        nib_ready = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            bus_nibble = 4'($urandom);
            tick();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL drain_flow cyc %0d: dut=%h model=%h", i, obs_vec(), exp_vec());
            end
            if (nib_valid) begin
                seen = 1'b1;
                n_cmp++;
                if (nib_addr !== 20'h12345) begin
                    n_bad++;
                    $display("FAIL drain_first: got nib_addr=%h, want 12345", nib_addr);
                end
            end
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL drain_timeout: got no nib_valid in 10 cycles, want one");
        end
    endtask

    task automatic test_wrap();
        logic [19:0] got[$];
        logic [19:0] want[4];
        want[0] = 20'hFFFFE; want[1] = 20'hFFFFF; want[2] = 20'h00000; want[3] = 20'h00001;
        drive_quiet();
        bus_ack = 1'b1; redirect_en = 1'b1; redirect_pc = 20'hFFFFE;
        tick();
        redirect_en = 1'b0; nib_ready = 1'b1;
        for (int i = 0; i < 20 && got.size() < 4; i++) begin
            bus_nibble = 4'($urandom);
            tick();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL wrap_flow cyc %0d: dut=%h model=%h", i, obs_vec(), exp_vec());
            end
            if (nib_valid) got.push_back(nib_addr);
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (k >= got.size() || got[k] !== want[k]) begin
                n_bad++;
                $display("FAIL wrap_addr %0d: got %h, want %h", k, (k < got.size()) ? got[k] : 20'hxxxxx, want[k]);
            end
        end
    endtask

    task automatic test_fault();
        int delivered = 0;
        int reads = 0;
        drive_quiet();
        do_reset();
        redirect_en = 1'b1; redirect_pc = 20'h00002;
        tick();
        redirect_en = 1'b0; bus_ack = 1'b1;
        for (int i = 0; i < 20 && !m_fault; i++) begin
            bus_nibble = 4'($urandom);
            bus_error = m_out && (m_oaddr == 20'h00005);
            tick();
        end
        bus_error = 1'b0;
        n_cmp++;
        if (fault !== 1'b1 || fault_addr !== 20'h00005 || bus_read !== 1'b0 || nib_addr !== 20'h00002) begin
            n_bad++;
            $display("FAIL fault_set: got f=%b fa=%h rd=%b head=%h, want 1 00005 0 00002",
                     fault, fault_addr, bus_read, nib_addr);
        end
        nib_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (nib_valid) delivered++;
            if (bus_read) reads++;
            tick();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL fault_drain cyc %0d: dut=%h model=%h", i, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (delivered !== 3 || reads !== 0 || fault !== 1'b1) begin
            n_bad++;
            $display("FAIL fault_hold: got delivered=%0d reads=%0d f=%b, want 3 0 1", delivered, reads, fault);
        end
        redirect_en = 1'b1; redirect_pc = 20'h00100;
        tick();
        redirect_en = 1'b0;
        n_cmp++;
        if (fault !== 1'b0 || bus_read !== 1'b1 || bus_addr !== 20'h00100) begin
            n_bad++;
            $display("FAIL fault_clear: got f=%b rd=%b addr=%h, want 0 1 00100", fault, bus_read, bus_addr);
        end
    endtask

    task automatic test_reset_mid();
        drive_quiet();
        do_reset();
        tick();
        reset = 1'b1;
        tick();
        n_cmp++;
        if ({bus_read, nib_valid, fault} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_midread: got rd=%b v=%b f=%b, want 0 0 0", bus_read, nib_valid, fault);
        end
        reset = 1'b0; bus_ack = 1'b1;
        for (int i = 0; i < 14; i++) begin
            bus_nibble = 4'($urandom);
            tick();
        end
        reset = 1'b1;
        tick();
        n_cmp++;
        if ({bus_read, nib_valid, fault} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_full: got rd=%b v=%b f=%b, want 0 0 0", bus_read, nib_valid, fault);
        end
        reset = 1'b0;
        tick();
        n_cmp++;
        if (bus_read !== 1'b1 || bus_addr !== 20'h00000) begin
            n_bad++;
            $display("FAIL reset_first_read: got rd=%b addr=%h, want 1 00000", bus_read, bus_addr);
        end
    endtask

    task automatic test_random();
        drive_quiet();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 499) == 0);
            redirect_en = ($urandom_range(0, 39) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? 20'hFFFFC + 20'($urandom_range(0, 3))
                                                      : 20'($urandom);
            bus_ack     = 1'($urandom_range(0, 1));
            bus_error   = ($urandom_range(0, 29) == 0);
            nib_ready   = ($urandom_range(0, 9) < 6);
            bus_nibble  = 4'($urandom);
            tick();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL random cyc %0d: dut=%h model=%h", i, obs_vec(), exp_vec());
            end
        end
        drive_quiet();
    endtask

    initial begin
        drive_quiet();
        @(negedge strobe);
        test_reset();
        test_stream();
        test_full();
        test_redirect_drain();
        test_wrap();
        test_fault();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
